decoder_fifo: RTL and testbench
===============================

DECODER_FIFO -- requirements
Module: decoder_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count; power of two, minimum 2.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port clear, input, 1, synchronous flush of FIFO and counter.
REQ-005 SHALL have port in_valid, input, 1, producer asserts that in_code is valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept a code this cycle.
REQ-007 SHALL have port in_code, input, [0:2], binary code to decode.
REQ-008 SHALL have port out_valid, output, 1, out_onehot holds a valid decoded word.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts out_onehot this cycle.
REQ-010 SHALL have port out_onehot, output, [0:7], decoded one-hot word.
REQ-011 SHALL have port level, output, clog2(DEPTH)+1 bits, current FIFO occupancy.
REQ-012 SHALL have port count, output, [0:7], number of words delivered, modulo 256.

Function
REQ-013 SHALL decode code value k (0..7) to the 8-bit word whose numeric value is 1<<k (000 -> 8'b00000001, 111 -> 8'b10000000), with ascending-range ports, so that the team's 8-3 encoder, fed this output, returns the original code.
REQ-014 SHALL store received codes in a DEPTH-entry circular FIFO with separate read and write pointers that wrap from DEPTH-1 to 0.
REQ-015 SHALL accept a code (push) on a rising edge where in_valid=1 and in_ready=1.
REQ-016 SHALL drive in_ready = 1 when level < DEPTH, otherwise 0, independent of out_ready; a full FIFO accepts no push even on a simultaneous pop.
REQ-017 SHALL drive out_valid = 1 when level > 0, otherwise 0.
REQ-018 SHALL present the decode of the head entry on out_onehot (show-ahead); out_onehot SHALL be 8'b00000000 whenever out_valid=0.
REQ-019 SHALL remove the head entry (pop) on a rising edge where out_valid=1 and out_ready=1.
REQ-020 SHALL give one-cycle latency: a code pushed into an empty FIFO at edge N appears with out_valid=1 immediately after edge N.
REQ-021 SHALL hold out_onehot and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL leave level unchanged on a simultaneous push and pop, and SHALL increment it on push only and decrement it on pop only.
REQ-023 SHALL increment count by 1 on each pop, wrapping 255 -> 0.
REQ-024 SHALL ignore in_code while in_valid=0, and SHALL ignore out_ready while out_valid=0.
REQ-025 SHALL, on a rising edge with clear=1, set level, both pointers and count to 0; clear SHALL take priority over a simultaneous push or pop, and the codes involved are discarded without being counted.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force both pointers, level and count to 0, giving out_valid=0, out_onehot=8'b00000000 and in_ready=1.
REQ-027 SHALL discard all stored entries when reset asserts mid-operation; the first push after rst_n deasserts SHALL be the first word output.
REQ-028 SHALL leave FIFO storage contents unspecified after reset; they SHALL never be visible while out_valid=0.

Verification
REQ-029 SHALL verify the single-code path: push 3'b101 into an empty FIFO with out_ready=1 -> next cycle out_valid=1, out_onehot=8'b00100000; after the pop, count=1 and level=0.
REQ-030 SHALL verify fill and drain: push codes 0,1,2,3 (DEPTH=4) with out_ready=0 -> level=4 and in_ready=0; a fifth push is refused; then drain with out_ready=1 -> 8'h01, 8'h02, 8'h04, 8'h08 in order, and level=0.
REQ-031 SHALL verify simultaneous push and pop: at level=2, push 3'b111 while popping -> level stays 2, and 8'h80 is delivered last.
REQ-032 SHALL verify clear priority: with level=3 and in_valid=1, out_ready=1 and clear=1 on the same edge -> level=0, count=0, out_valid=0.
REQ-033 SHALL verify reset mid-stream: assert rst_n=0 asynchronously between edges with level=2 -> out_valid=0 and out_onehot=0 at once; after release, push 3'b000 -> output 8'b00000001.
REQ-034 SHALL verify round-trip and wrap: feed all 8 codes 32 times each (256 pops) through the team's 8-3 encoder -> every encoder output equals its input code, and count wraps to 0.

Source files
------------

// File: rtl/decoder_fifo.sv
// decoder_fifo: 3-to-8 one-hot decoder behind a DEPTH-entry show-ahead FIFO.
// Ports: clk, rst_n, clear | in_valid/in_ready/in_code | out_valid/out_ready/out_onehot | level, count.
module decoder_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [0:2]                 in_code,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [0:7]                 out_onehot,
    output logic [$clog2(DEPTH):0]     level,
    output logic [0:7]                 count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [2:0]    head;
    logic [2:0]    code_n;
    logic          push;
    logic          pop;

    // Codes are stored numerically; the ascending port range is only a view.
    assign code_n    = in_code;
    assign head      = mem[rd_ptr];

    assign in_ready  = (level < LW'(DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Stale storage is masked whenever the FIFO is empty.
    assign out_onehot = out_valid ? (8'd1 << head) : 8'd0;

    // Storage needs no reset: empty entries are never shown.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= code_n;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count + 8'd1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_fifo.sv
// tb_decoder_fifo: directed vector table plus corner-case sequences
// for decoder_fifo (DEPTH=4), including an 8-3 encoder round trip.
module tb_decoder_fifo;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [0:2] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [0:7] out_onehot;
    logic [2:0] level;
    logic [0:7] count;

    int total;
    int bad;

    decoder_fifo #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .level      (level),
        .count      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       clr;
        logic       iv;
        logic [2:0] code;
        logic       ordy;
        logic       ov;
        logic [7:0] oh;
        logic [2:0] lvl;
        logic       ir;
        logic [7:0] cnt;
    } vec_t;

    vec_t vt[20];

    function automatic vec_t mk(
        input logic clr, input logic iv,
        input logic [2:0] code, input logic ordy,
        input logic ov, input logic [7:0] oh,
        input logic [2:0] lvl, input logic ir,
        input logic [7:0] cnt);
        vec_t v;
        v.clr = clr; v.iv = iv; v.code = code;
        v.ordy = ordy; v.ov = ov; v.oh = oh;
        v.lvl = lvl; v.ir = ir; v.cnt = cnt;
        return v;
    endfunction

    // Team 8-3 encoder: index of the set bit, by numeric weight.
    function automatic logic [2:0] enc8(input logic [7:0] w);
        logic [2:0] e;
        e = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w[i]) e = 3'(i);
        end
        return e;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic iv,
                         input logic [2:0] code,
                         input logic ordy);
        logic [2:0] k;
        k = code;
        clear     = c;
        in_valid  = iv;
        in_code   = k;
        out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag,
                           input logic ov, input logic [7:0] oh,
                           input logic [2:0] lvl, input logic ir,
                           input logic [7:0] cnt);
        logic [7:0] ohn;
        logic [7:0] cn;
        ohn = out_onehot;
        cn  = count;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".out_onehot"}, 32'(ohn), 32'(oh));
        chk({tag, ".level"}, 32'(level), 32'(lvl));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
        chk({tag, ".count"}, 32'(cn), 32'(cnt));
    endtask

    initial begin
        logic [2:0] k;
        total = 0;
        bad   = 0;

        // clr iv code or | ov oh lvl ir cnt (outputs before the edge)
        vt[0]  = mk(0,0,3'd6,1, 0,8'h00,3'd0,1,8'd0);
        vt[1]  = mk(0,1,3'd5,0, 0,8'h00,3'd0,1,8'd0);
        vt[2]  = mk(0,0,3'd6,1, 1,8'h20,3'd1,1,8'd0);
        vt[3]  = mk(0,0,3'd6,0, 0,8'h00,3'd0,1,8'd1);
        vt[4]  = mk(0,1,3'd0,0, 0,8'h00,3'd0,1,8'd1);
        vt[5]  = mk(0,1,3'd1,0, 1,8'h01,3'd1,1,8'd1);
        vt[6]  = mk(0,1,3'd2,0, 1,8'h01,3'd2,1,8'd1);
        vt[7]  = mk(0,1,3'd3,0, 1,8'h01,3'd3,1,8'd1);
        vt[8]  = mk(0,1,3'd7,0, 1,8'h01,3'd4,0,8'd1);
        vt[9]  = mk(0,1,3'd6,1, 1,8'h01,3'd4,0,8'd1);
        vt[10] = mk(0,0,3'd6,1, 1,8'h02,3'd3,1,8'd2);
        vt[11] = mk(0,0,3'd6,1, 1,8'h04,3'd2,1,8'd3);
        vt[12] = mk(0,0,3'd6,1, 1,8'h08,3'd1,1,8'd4);
        vt[13] = mk(0,0,3'd6,0, 0,8'h00,3'd0,1,8'd5);
        vt[14] = mk(0,1,3'd2,0, 0,8'h00,3'd0,1,8'd5);
        vt[15] = mk(0,1,3'd4,0, 1,8'h04,3'd1,1,8'd5);
        vt[16] = mk(0,1,3'd7,1, 1,8'h04,3'd2,1,8'd5);
        vt[17] = mk(0,0,3'd6,1, 1,8'h10,3'd2,1,8'd6);
        vt[18] = mk(0,0,3'd6,1, 1,8'h80,3'd1,1,8'd7);
        vt[19] = mk(0,0,3'd6,0, 0,8'h00,3'd0,1,8'd8);

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        #12;
        chk_all("reset", 1'b0, 8'h00, 3'd0, 1'b1, 8'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].clr, vt[i].iv, vt[i].code, vt[i].ordy);
            #3;
            chk_all($sformatf("vec%0d", i), vt[i].ov, vt[i].oh,
                    vt[i].lvl, vt[i].ir, vt[i].cnt);
            @(posedge clk);
            #1;
        end

        // clear beats a simultaneous push and pop
        drive(1'b0, 1'b1, 3'd1, 1'b0); step();
        drive(1'b0, 1'b1, 3'd2, 1'b0); step();
        drive(1'b0, 1'b1, 3'd3, 1'b0); step();
        chk("clr.pre_level", 32'(level), 32'd3);
        drive(1'b1, 1'b1, 3'd5, 1'b1); step();
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        chk_all("clr", 1'b0, 8'h00, 3'd0, 1'b1, 8'd0);
        drive(1'b0, 1'b1, 3'd6, 1'b0); step();
        drive(1'b0, 1'b0, 3'd0, 1'b1);
        chk("clr.head", 32'(out_onehot), 32'h40);
        step();
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        chk("clr.pop_count", 32'(count), 32'd1);
        chk("clr.pop_level", 32'(level), 32'd0);

        // asynchronous reset between edges
        drive(1'b0, 1'b1, 3'd2, 1'b0); step();
        drive(1'b0, 1'b1, 3'd3, 1'b0); step();
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        chk("rst.pre_level", 32'(level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("rst", 1'b0, 8'h00, 3'd0, 1'b1, 8'd0);
        #2;
        rst_n = 1'b1;
        step();
        drive(1'b0, 1'b1, 3'd0, 1'b0); step();
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        chk_all("rst.first", 1'b1, 8'h01, 3'd1, 1'b1, 8'd0);
        drive(1'b1, 1'b0, 3'd0, 1'b0); step();
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        chk("rst.clr_level", 32'(level), 32'd0);

        // streaming round trip through the encoder, 256 pops
        for (int c = 0; c <= 256; c++) begin
            k = 3'(c % 8);
            drive(1'b0, (c < 256), k, 1'b1);
            #3;
            if (c > 0) begin
                k = 3'((c - 1) % 8);
                chk($sformatf("rt%0d.valid", c),
                    32'(out_valid), 32'd1);
                chk($sformatf("rt%0d.enc", c),
                    32'(enc8(out_onehot)), 32'(k));
                chk($sformatf("rt%0d.onehot", c),
                    32'(out_onehot), 32'(8'd1 << k));
            end
            if (c == 256) begin
                chk("rt.count255", 32'(count), 32'd255);
            end
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        #3;
        chk_all("rt.end", 1'b0, 8'h00, 3'd0, 1'b1, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
